// File: rtl/fmac_arb_pkg.sv
// Shared types and helpers for the packet-atomic MAC FIFO write arbiter.
package fmac_arb_pkg;

    localparam int DEPTH_DEF = 512;
    localparam int PTR_DEF   = 9;
    localparam int LEN_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fmac_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after ptr, wrapping.
module fmac_rr_pick
    import fmac_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int unsigned j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 32'(ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && eligible[j]) begin
                onehot[j] = 1'b1;
                idx       = IDX_W'(j);
                found     = 1'b1;
            end
            j = rr_next(j, N_REQ);
        end
    end

endmodule

// File: rtl/fmac_fifo_wr_arb.sv
// Packet-atomic round-robin write arbiter for a shared MAC FIFO.
// Optional length checking (len_err/len_err_src) is enabled by defining FMAC_ARB_LEN_CHECK_EN.
module fmac_fifo_wr_arb
    import fmac_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 64,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR   = PTR_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    input  logic [N_REQ-1:0]       in_valid,
    input  logic [N_REQ-1:0]       in_last,
    output logic [N_REQ-1:0]       in_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   fifo_wrreq,
    output logic [WIDTH-1:0]       fifo_data,
    input  logic                   fifo_full,
    input  logic [PTR:0]           fifo_usedw,
    output logic                   busy
`ifdef FMAC_ARB_LEN_CHECK_EN
    ,
    output logic                   len_err,
    output logic [N_REQ-1:0]       len_err_src
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    // Free space DEPTH-1-usedw, clamped at zero so an overfull level never wraps positive.
    function automatic logic [LEN_W:0] room_sat(input logic [PTR:0] usedw);
        logic signed [LEN_W+1:0] diff;
        diff = $signed((LEN_W+2)'(DEPTH - 1)) - $signed({1'b0, (LEN_W+1)'(usedw)});
        return (diff < 0) ? '0 : diff[LEN_W:0];
    endfunction

    state_t             state, state_n;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   ptr;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W:0]     room;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               found;
    logic [LEN_W-1:0]   pick_len;
    logic               xfer;
    logic               sel_valid;
    logic               sel_last;
    logic [WIDTH-1:0]   sel_data;
    logic               accept;
    logic               last_word;

    assign room = room_sat(fifo_usedw);

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0) &&
                          ({1'b0, req_len[i*LEN_W +: LEN_W]} <= room);
        end
    end

    fmac_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .found    (found)
    );

    assign pick_len  = req_len[pick_idx*LEN_W +: LEN_W];

    assign xfer      = (state == XFER);
    assign sel_valid = in_valid[gidx];
    assign sel_last  = in_last[gidx];
    assign sel_data  = in_data[gidx*WIDTH +: WIDTH];

    assign in_ready   = (xfer && !fifo_full) ? grant : '0;
    assign fifo_wrreq = xfer && sel_valid && !fifo_full;
    assign fifo_data  = xfer ? sel_data : '0;
    assign accept     = fifo_wrreq;
    // A packet ends on whichever comes first: the source's in_last or the reserved length.
    assign last_word  = accept && (sel_last || (cnt == LEN_W'(1)));
    assign busy       = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = XFER;
            XFER:    if (last_word) state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                grant <= pick_onehot;
                gidx  <= pick_idx;
                cnt   <= pick_len;
            end
            if (accept) cnt <= cnt - LEN_W'(1);
            if (last_word) begin
                grant <= '0;
                ptr   <= IDX_W'(rr_next(32'(gidx), N_REQ));
            end
        end
    end

`ifdef FMAC_ARB_LEN_CHECK_EN
    // In_last and counter exhaustion must coincide; either one alone is a length error.
    logic len_bad;
    assign len_bad = accept && (sel_last != (cnt == LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (srst) begin
            len_err     <= 1'b0;
            len_err_src <= '0;
        end else begin
            len_err <= len_bad;
            if (len_bad) len_err_src <= grant;
        end
    end
`endif

endmodule

// File: doc/fmac_fifo_wr_arb.md
Name: fmac_fifo_wr_arb

Overview:
- Packet-atomic round-robin write arbiter in front of one shared single-clock 512x64 MAC FIFO (srst/clk variant).
- Shares the FIFO write port between N_REQ word-stream sources, e.g. per-queue TX staging.
- Grants a source only when the FIFO has room for that source's whole packet, so packets never interleave and never stall mid-packet on full.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 64, FIFO data width in bits.
- DEPTH, 512, FIFO depth in words.
- PTR, 9, log2(DEPTH).
- LEN_W, 10, packet length field width in words (PTR+1).

Ports:
- clk  in  1  single clock for arbiter and FIFO.
- srst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-source packet pending.
- req_len  in  N_REQ*LEN_W  per-source packet length in words, stable while req=1.
- in_data  in  N_REQ*WIDTH  per-source word.
- in_valid  in  N_REQ  per-source word valid.
- in_last  in  N_REQ  marks final word of packet.
- in_ready  out  N_REQ  word accepted when in_valid&in_ready.
- grant  out  N_REQ  one-hot owner of the FIFO write port.
- fifo_wrreq  out  1  to FIFO wr_en.
- fifo_data  out  WIDTH  to FIFO din.
- fifo_full  in  1  from FIFO full.
- fifo_usedw  in  PTR+1  FIFO fill level, {1'b0,data_count}.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, XFER, GAP.
- Reset (srst=1 at clk edge):
  - state=IDLE, grant=0, in_ready=0, fifo_wrreq=0, fifo_data=0, busy=0.
  - RR pointer = 0.
  - Reset mid-XFER abandons the packet; the partial packet is not recovered.
- Eligibility: source i is eligible when req[i]=1 and 1 <= len_i <= DEPTH-1-fifo_usedw, computed in LEN_W+1 bits and never negative. len=0 or len>=DEPTH is never eligible and is skipped without stalling others.
- IDLE:
  - Pick the first eligible source at or after the RR pointer, wrapping at N_REQ-1 to 0.
  - Register grant one-hot, load word counter with len, go to XFER next cycle.
  - Latency: req to grant is 1 cycle.
  - No eligible source: stay in IDLE.
- XFER:
  - in_ready = grant & ~fifo_full.
  - fifo_wrreq = in_valid[g] & in_ready[g]; fifo_data = in_data[g]. Both combinational from the granted lane.
  - Counter decrements on each accepted word.
  - On an accepted word with in_last=1 or counter==1: drop grant, set RR pointer to g+1 mod N_REQ, go to GAP.
  - Non-granted lanes: in_ready=0.
- GAP:
  - Exactly 1 cycle, grant=0, so fifo_usedw reflects the last write before the next space check.
  - Then IDLE.
- fifo_full during XFER only pauses transfer; it is not an error because space was reserved.
- Simultaneous requests: RR order. After g finishes, g+1 has priority.
- Back-to-back packets from one source: at least 2 idle cycles between them (GAP + IDLE).
- busy=1 in XFER and GAP.

Optional Feature:
- FMAC_ARB_LEN_CHECK_EN:
  - Defined: adds outputs len_err (1-cycle pulse) and len_err_src (one-hot, held until next error or srst).
    - Early in_last (counter>1): pulse and end the packet.
    - Counter reaching 0 without in_last: pulse and end the packet.
  - Undefined: ports absent; whichever of in_last or counter exhaustion comes first ends the packet silently.

Decomposition:
- Package fmac_arb_pkg: DEPTH/PTR/LEN_W defaults, state encoding (IDLE=2'd0, XFER=2'd1, GAP=2'd2), RR next-index function.
- Sub-module fmac_rr_pick: combinational round-robin picker. Inputs eligible vector and pointer; outputs one-hot and index.

Test Plan:
- srst held 3 cycles, then released with req=2'b11, len=4/4, usedw=0 -> grant=01 on cycle 1; 4 writes; GAP; grant=10; 4 writes; 8 total words in order.
- usedw=508, src0 len=4 -> no grant (needs <=3). usedw drops to 507 -> grant next cycle.
- src0 len=0 and src1 len=2, both req -> src0 skipped, src1 granted, no deadlock.
- fifo_full pulsed 3 cycles mid-packet -> in_ready=0 and fifo_wrreq=0 for those cycles, packet completes intact.
- srst asserted on word 2 of a len=6 packet -> next cycle state IDLE, all outputs 0, RR pointer 0.
- With FMAC_ARB_LEN_CHECK_EN: len=5 with in_last on word 3 -> len_err pulse, len_err_src=01, GAP follows.
